ps2_frame_receiver_fifo: RTL

//  Parametrised serial-frame receiver for PS/2-style keyboard/device links. Synchronises and debounces
//  the device clock, deserialises start/data/parity/stop frames and checks parity (none/odd/even) and framing.

---
 rtl/ps2_frame_receiver_fifo_pkg.sv | 28 ++
 rtl/ps2_frame_receiver_fifo_sync_fifo.sv | 54 +++++
 rtl/ps2_frame_receiver_fifo.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_frame_receiver_fifo_pkg.sv
// Shared types and constants for the PS/2 frame receiver: FSM encoding,
// parity-mode selectors and the parity acceptance rule.
package ps2_frame_receiver_fifo_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StData   = 2'd1,
    StParity = 2'd2,
    StStop   = 2'd3
  } rx_state_e;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  // data_xor is the XOR-reduction of the received data bits.
  function automatic logic parity_ok(input int unsigned mode, input logic data_xor,
                                     input logic par_bit);
    logic ok;
    case (mode)
      PARITY_ODD:  ok = (data_xor ^ par_bit);
      PARITY_EVEN: ok = ~(data_xor ^ par_bit);
      default:     ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ps2_frame_receiver_fifo_sync_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted only when
// a pop happens in the same cycle.
module ps2_frame_receiver_fifo_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CntW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is only meaningful when not empty.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/ps2_frame_receiver_fifo.sv
// PS/2-style frame receiver: synchronise and debounce the device clock, shift in
// start/data/parity/stop, check the frame and queue good data in a FIFO.
module ps2_frame_receiver_fifo
  import ps2_frame_receiver_fifo_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned PARITY_MODE = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 4,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ser_clk,
  input  logic              i_ser_data,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_fifo_full,
  output logic              o_parity_err,
  output logic              o_frame_err,
  output logic              o_overflow
);

  localparam int unsigned DbW     = $clog2(DEBOUNCE + 1);
  localparam int unsigned ToW     = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned BitCntW = $clog2(DATA_W + 1);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic [DbW-1:0]         r_db_cnt;
  logic                   r_clk_filt;
  logic                   r_clk_filt_prev;
  logic                   w_clk_s;
  logic                   w_data_s;
  logic                   w_strobe;

  rx_state_e              r_state;
  rx_state_e              w_state_d;
  logic [DATA_W-1:0]      r_shift;
  logic [DATA_W-1:0]      w_shift_next;
  logic [BitCntW-1:0]     r_bit_cnt;
  logic                   r_par_bit;
  logic [ToW-1:0]         r_to_cnt;
  logic                   w_timeout;
  logic                   w_last_bit;

  logic                   w_shift_en;
  logic                   w_par_cap;
  logic                   w_push_d;
  logic                   w_perr_d;
  logic                   w_ferr_d;
  logic                   r_push;
  logic                   r_perr;
  logic                   r_ferr;

  logic [DATA_W-1:0]      w_head;
  logic                   w_full;
  logic                   w_empty;

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];
  assign w_strobe = r_clk_filt_prev & ~r_clk_filt;

  // Chains preset to 1 so reset looks like an idle line and cannot fake a strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_clk_sync      <= '1;
      r_data_sync     <= '1;
      r_db_cnt        <= '0;
      r_clk_filt      <= 1'b1;
      r_clk_filt_prev <= 1'b1;
    end else begin
      r_clk_sync      <= {r_clk_sync[SYNC_STAGES-2:0], i_ser_clk};
      r_data_sync     <= {r_data_sync[SYNC_STAGES-2:0], i_ser_data};
      r_clk_filt_prev <= r_clk_filt;
      if (w_clk_s == r_clk_filt) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DbW'(DEBOUNCE - 1)) begin
        r_db_cnt   <= '0;
        r_clk_filt <= w_clk_s;
      end else begin
        r_db_cnt <= r_db_cnt + DbW'(1);
      end
    end
  end

  assign w_last_bit = (r_bit_cnt == BitCntW'(DATA_W - 1));
  assign w_timeout  = (r_state != StIdle) && (r_to_cnt == ToW'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (w_strobe && !w_data_s) w_state_d = StData;
      StData:   if (w_strobe && w_last_bit) begin
                  w_state_d = (PARITY_MODE != PARITY_NONE) ? StParity : StStop;
                end
      StParity: if (w_strobe) w_state_d = StStop;
      StStop:   if (w_strobe) w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
    if (!w_strobe && w_timeout) w_state_d = StIdle;
  end

  always_comb begin
    w_shift_en = 1'b0;
    w_par_cap  = 1'b0;
    w_push_d   = 1'b0;
    w_perr_d   = 1'b0;
    w_ferr_d   = 1'b0;
    unique case (r_state)
      StIdle:   ;
      StData:   w_shift_en = w_strobe;
      StParity: w_par_cap  = w_strobe;
      StStop:   if (w_strobe) begin
                  w_ferr_d = ~w_data_s;
                  w_perr_d = ~parity_ok(PARITY_MODE, ^r_shift, r_par_bit);
                  w_push_d = w_data_s & parity_ok(PARITY_MODE, ^r_shift, r_par_bit);
                end
      default:  ;
    endcase
    if (!w_strobe && w_timeout) w_ferr_d = 1'b1;
  end

  always_comb begin
    w_shift_next = r_shift >> 1;
    w_shift_next[DATA_W-1] = w_data_s;
  end

  // r_shift holds the completed frame until the next start bit, so it feeds the push directly.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par_bit <= 1'b0;
      r_to_cnt  <= '0;
      r_push    <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_push <= w_push_d;
      r_perr <= w_perr_d;
      r_ferr <= w_ferr_d;
      if (r_state == StIdle) r_bit_cnt <= '0;
      else if (w_shift_en)   r_bit_cnt <= r_bit_cnt + BitCntW'(1);
      if (w_shift_en) r_shift   <= w_shift_next;
      if (w_par_cap)  r_par_bit <= w_data_s;
      if (r_state == StIdle || w_strobe || w_timeout) r_to_cnt <= '0;
      else                                            r_to_cnt <= r_to_cnt + ToW'(1);
    end
  end

  ps2_frame_receiver_fifo_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (r_push),
    .i_pop   (i_rd_en),
    .i_data  (r_shift),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_rd_valid   = ~w_empty;
  assign o_rd_data    = w_empty ? '0 : w_head;
  assign o_fifo_full  = w_full;
  assign o_parity_err = r_perr;
  assign o_frame_err  = r_ferr;
  // Full implies non-empty, so a raised i_rd_en always frees a slot.
  assign o_overflow   = r_push & w_full & ~i_rd_en;

endmodule
